eth_ram_wr_ctrl: RTL

Write-side sequencer for the Ethernet-to-HDMI line RAM. It runs in the `clk_ref` domain and accepts the UDP payload byte stream from the Ethernet receiver. Each packet carries one video line. The block packs bytes big-endian into 16-bit pixels and maps each line to one of 2^SLOT_W ring slots in the 8K x 16 RAM. It drives `des_addr` / `des_data` / `eth_wr_ram_en`, and reports each completed line to the HDMI read side, which performs its own CDC.

---
 rtl/eth_ram_wr_if.sv | 26 ++
 rtl/eth_ram_wr_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/eth_ram_wr_if.sv
// Payload-in / RAM-write-out bundle for the Ethernet line RAM write sequencer.
// The slave modport is the sequencer side; the master drives the byte stream.
interface eth_ram_wr_if #(
  parameter int ADDR_W = 13,
  parameter int SLOT_W = 3
);
  logic                   rec_en;
  logic [7:0]             rec_data;
  logic                   rec_pkt_done;
  logic [ADDR_W-1:0]      des_addr;
  logic [15:0]            des_data;
  logic                   eth_wr_ram_en;
  logic                   line_done;
  logic [15:0]            line_row;
  logic [ADDR_W-SLOT_W:0] line_words;
  logic                   pkt_err;

  modport master (
    output rec_en, rec_data, rec_pkt_done,
    input  des_addr, des_data, eth_wr_ram_en, line_done, line_row, line_words, pkt_err
  );
  modport slave (
    input  rec_en, rec_data, rec_pkt_done,
    output des_addr, des_data, eth_wr_ram_en, line_done, line_row, line_words, pkt_err
  );
endinterface

// File: rtl/eth_ram_wr_ctrl.sv
// Packs the UDP payload byte stream big-endian into 16-bit pixels and writes each
// line into a ring slot of the line RAM. Macro ETH_RAM_ROW_HDR_EN: row from a 2-byte header.
module eth_ram_wr_ctrl #(
  parameter int ADDR_W = 13,
  parameter int SLOT_W = 3
) (
  input  logic         clk_ref,
  input  logic         rst,
  eth_ram_wr_if.slave  bus
);
  localparam int WA_W  = ADDR_W - SLOT_W;
  localparam int WC_W  = WA_W + 1;
  localparam int WORDS = 1 << WA_W;

  typedef enum logic [1:0] {IDLE, HDR_HI, HDR_LO, DATA} state_t;

  state_t            state, state_n;
  logic [7:0]        hi_q, hi_n;
  logic              pend_q, pend_n;
  logic              err_q, err_n;
  logic [SLOT_W-1:0] slot_q, slot_n;
  logic [WC_W-1:0]   wc_q, wc_n;
  logic [15:0]       row_q, row_n;

  logic              wr_n, done_n, lerr_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       data_n, lrow_n;
  logic [WC_W-1:0]   lwords_n;
  logic              act, close;
`ifndef ETH_RAM_ROW_HDR_EN
  logic [15:0]       line_cnt, cnt_n;
`endif

  always_comb begin
    state_n  = state;
    hi_n     = hi_q;
    pend_n   = pend_q;
    err_n    = err_q;
    slot_n   = slot_q;
    wc_n     = wc_q;
    row_n    = row_q;
    wr_n     = 1'b0;
    addr_n   = bus.des_addr;
    data_n   = bus.des_data;
    done_n   = 1'b0;
    lrow_n   = bus.line_row;
    lwords_n = bus.line_words;
    lerr_n   = bus.pkt_err;
    act      = 1'b0;
    close    = 1'b0;
`ifndef ETH_RAM_ROW_HDR_EN
    cnt_n    = line_cnt;
`endif

    case (state)
      IDLE, HDR_HI: begin
`ifdef ETH_RAM_ROW_HDR_EN
        if (bus.rec_en) begin
          hi_n    = bus.rec_data;
          state_n = HDR_LO;
          if (bus.rec_pkt_done) begin
            // packet ended after the first header byte
            done_n   = 1'b1;
            lrow_n   = '0;
            lwords_n = '0;
            lerr_n   = 1'b1;
            state_n  = IDLE;
          end
        end
`else
        if (bus.rec_en) begin
          row_n   = line_cnt;
          slot_n  = line_cnt[SLOT_W-1:0];
          wc_n    = '0;
          pend_n  = 1'b0;
          err_n   = 1'b0;
          state_n = DATA;
          act     = 1'b1;
          close   = bus.rec_pkt_done;
        end
`endif
      end
`ifdef ETH_RAM_ROW_HDR_EN
      HDR_LO: begin
        if (bus.rec_en) begin
          row_n   = {hi_q, bus.rec_data};
          slot_n  = bus.rec_data[SLOT_W-1:0];
          wc_n    = '0;
          pend_n  = 1'b0;
          err_n   = 1'b0;
          state_n = DATA;
          close   = bus.rec_pkt_done;
        end else if (bus.rec_pkt_done) begin
          done_n   = 1'b1;
          lrow_n   = '0;
          lwords_n = '0;
          lerr_n   = 1'b1;
          state_n  = IDLE;
        end
      end
`endif
      DATA: begin
        act   = bus.rec_en;
        close = bus.rec_pkt_done;
      end
      default: state_n = IDLE;
    endcase

    // byte is consumed before the packet closes; a full slot drops it
    if (act) begin
      if (wc_n == WC_W'(WORDS)) begin
        err_n = 1'b1;
      end else if (!pend_n) begin
        hi_n   = bus.rec_data;
        pend_n = 1'b1;
      end else begin
        wr_n   = 1'b1;
        addr_n = {slot_n, wc_n[WA_W-1:0]};
        data_n = {hi_n, bus.rec_data};
        wc_n   = wc_n + WC_W'(1);
        pend_n = 1'b0;
      end
    end

    if (close) begin
      if (pend_n) begin
        wr_n   = 1'b1;
        addr_n = {slot_n, wc_n[WA_W-1:0]};
        data_n = {hi_n, 8'h00};
        wc_n   = wc_n + WC_W'(1);
        pend_n = 1'b0;
      end
      done_n   = 1'b1;
      lrow_n   = row_n;
      lwords_n = wc_n;
      lerr_n   = err_n;
      state_n  = IDLE;
`ifndef ETH_RAM_ROW_HDR_EN
      cnt_n    = line_cnt + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      hi_q              <= '0;
      pend_q            <= 1'b0;
      err_q             <= 1'b0;
      slot_q            <= '0;
      wc_q              <= '0;
      row_q             <= '0;
      bus.des_addr      <= '0;
      bus.des_data      <= '0;
      bus.eth_wr_ram_en <= 1'b0;
      bus.line_done     <= 1'b0;
      bus.line_row      <= '0;
      bus.line_words    <= '0;
      bus.pkt_err       <= 1'b0;
`ifndef ETH_RAM_ROW_HDR_EN
      line_cnt          <= '0;
`endif
    end else begin
      state             <= state_n;
      hi_q              <= hi_n;
      pend_q            <= pend_n;
      err_q             <= err_n;
      slot_q            <= slot_n;
      wc_q              <= wc_n;
      row_q             <= row_n;
      bus.des_addr      <= addr_n;
      bus.des_data      <= data_n;
      bus.eth_wr_ram_en <= wr_n;
      bus.line_done     <= done_n;
      bus.line_row      <= lrow_n;
      bus.line_words    <= lwords_n;
      bus.pkt_err       <= lerr_n;
`ifndef ETH_RAM_ROW_HDR_EN
      line_cnt          <= cnt_n;
`endif
    end
  end
endmodule
